// File: rtl/input_capture_pkg.sv
// Shared register map and types for the switch/button input-capture slave.
package input_capture_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_POL  = 2'd3;

  typedef logic [3:0] cnt_t;

endpackage

// File: rtl/debounce_cell.sv
// One input: 2-flop synchroniser, tick-paced stability counter and debounced level.
module debounce_cell
  import input_capture_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic state,
  output logic changed
);

  // Reaching this count on a disagreeing tick means STABLE_TICKS in a row.
  localparam cnt_t CNT_LAST = cnt_t'(STABLE_TICKS - 1);

  logic sync1;
  logic sync2;
  cnt_t cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      cnt     <= '0;
      state   <= 1'b0;
      changed <= 1'b0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      changed <= 1'b0;
      if (tick) begin
        if (sync2 != state) begin
          if (cnt == CNT_LAST) begin
            state   <= ~state;
            cnt     <= '0;
            changed <= 1'b1;
          end else begin
            cnt <= cnt + cnt_t'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/input_capture_slave.sv
// Avalon-MM slave exposing debounced switches/buttons with W1C edge capture and a level irq.
module input_capture_slave
  import input_capture_pkg::*;
#(
  parameter int unsigned N_IN         = 14,
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] raw_in,
  input  logic [1:0]      avs_address,
  input  logic            avs_read,
  input  logic            avs_write,
  input  logic [31:0]     avs_writedata,
  output logic [31:0]     avs_readdata,
  output logic            irq
);

  localparam int unsigned PW = $clog2(TICK_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [4:0]    ARM_LAST   = 5'(STABLE_TICKS);

  logic [PW-1:0]   presc;
  logic            tick;
  logic [4:0]      arm_cnt;
  logic            armed;
  logic [N_IN-1:0] state;
  logic [N_IN-1:0] changed;
  logic [N_IN-1:0] ev;
  logic [N_IN-1:0] w1c;
  logic [N_IN-1:0] edge_reg;
  logic [N_IN-1:0] mask_reg;
  logic [N_IN-1:0] pol_reg;
  logic [31:0]     rd_word;
  logic            wdata_unused;

  assign wdata_unused = ^avs_writedata;
  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Arm only once every input has had a full stability window after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (tick && !armed) begin
      if (arm_cnt == ARM_LAST) begin
        armed <= 1'b1;
      end else begin
        arm_cnt <= arm_cnt + 5'd1;
      end
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : gen_cells
    debounce_cell #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_cell (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (raw_in[i]),
      .state  (state[i]),
      .changed(changed[i])
    );
  end

  assign ev  = {N_IN{armed}} & changed & (state ^ pol_reg);
  assign w1c = (avs_write && avs_address == ADDR_EDGE) ? avs_writedata[N_IN-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_reg <= '0;
      mask_reg <= '0;
      pol_reg  <= '0;
      irq      <= 1'b0;
    end else begin
      edge_reg <= (edge_reg & ~w1c) | ev;
      if (avs_write && avs_address == ADDR_MASK) mask_reg <= avs_writedata[N_IN-1:0];
      if (avs_write && avs_address == ADDR_POL)  pol_reg  <= avs_writedata[N_IN-1:0];
      irq <= |(edge_reg & mask_reg);
    end
  end

  always_comb begin
    rd_word = '0;
    case (avs_address)
      ADDR_DATA: rd_word[N_IN-1:0] = state;
      ADDR_EDGE: rd_word[N_IN-1:0] = edge_reg;
      ADDR_MASK: rd_word[N_IN-1:0] = mask_reg;
      ADDR_POL:  rd_word[N_IN-1:0] = pol_reg;
      default:   rd_word = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
    end else if (avs_read) begin
      avs_readdata <= rd_word;
    end
  end

endmodule
